wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Round-robin Wishbone B4 (classic) arbiter: NM masters share one slave port.
//  Sits between the SCR1 instr/data masters and a single shared slave, e.g. firmware RAM on a low-area build without wbxbar.
//  Grant is held for the whole master cycle (CYC). A bus watchdog terminates hung cycles with ERR.
// PARAMETERS
//  NM       2     number of masters (1..8); master 0 = lowest index
//  AW       32    address width
//  DW       32    data width (SEL width = DW/8)
//  TIMEOUT  255   cycles of STB without ACK before ERR; 0 disables the watchdog
// PORTS
//  wb_clk_i     in   1        clock
//  wb_rst_i     in   1        reset, synchronous, active-high
//  m_cyc_i      in   NM       master CYC, bit i = master i
//  m_stb_i      in   NM       master STB
//  m_we_i       in   NM       master WE
//  m_adr_i      in   NM*AW    master address, master i at [i*AW +: AW]
//  m_dat_i      in   NM*DW    master write data
//  m_sel_i      in   NM*DW/8  master byte selects
//  m_dat_o      out  DW       read data, broadcast to all masters
//  m_ack_o      out  NM       ACK, granted master only
//  m_err_o      out  NM       ERR (watchdog), granted master only
//  s_cyc_o/s_stb_o/s_we_o  out 1 each   slave control
//  s_adr_o      out  AW       slave address
//  s_dat_o      out  DW       slave write data
//  s_sel_o      out  DW/8     slave byte selects
//  s_dat_i      in   DW       slave read data
//  s_ack_i      in   1        slave ACK
//  grant_o      out  NM       one-hot current grant (debug/perf)
// BEHAVIOUR
//  - Reset: state=IDLE, grant_o=0, last pointer=NM-1 (master 0 wins first), wd counter=0.
//    All s_*_o, m_ack_o and m_err_o read 0 from the cycle after the reset edge.
//    Reset mid-cycle abandons the transfer. No ACK or ERR is issued for it.
//  - FSM IDLE: if any m_cyc_i is set, pick the first requester searching
//    last+1, last+2, ... (mod NM). Register grant and last pointer, then go to BUSY.
//    The arbitration latency is 1 cycle: s_cyc_o rises the cycle after m_cyc_i.
//  - FSM BUSY: the slave bus is a combinational mux of the granted master's signals.
//    s_cyc_o = m_cyc_i[g]. s_stb_o = m_cyc_i[g] & m_stb_i[g].
//    m_ack_o[g] = s_ack_i. All other ACK bits are 0. m_dat_o = s_dat_i always.
//  - BUSY -> IDLE when m_cyc_i[g]==0. grant_o clears on that edge. The IDLE cycle that follows re-arbitrates.
//    The minimum bubble between cycles of different masters is 1 cycle.
//  - Requests from non-granted masters are ignored in BUSY; they wait, with no ACK.
//  - Back-to-back STBs within one CYC stay granted; there is no preemption.
//  - Watchdog (TIMEOUT>0): counter counts up while BUSY & s_stb_o & !s_ack_i.
//    It clears on ACK, on STB low, and in IDLE.
//    On the cycle it reaches TIMEOUT:
//      m_err_o[g]=1 for exactly one cycle; s_stb_o and s_cyc_o are forced to 0 on that cycle;
//      the FSM goes to IDLE and the last pointer stays at g.
//    The master must drop CYC after ERR. If it holds CYC, it re-enters arbitration like any requester.
//  - If s_ack_i and the timeout coincide, ACK wins: no ERR, and the counter clears.
//  - s_ack_i while IDLE is dropped (not forwarded).
//  - NM==1: degenerates to a pass-through with the same 1-cycle grant latency and watchdog.
//  - Counter width = $clog2(TIMEOUT+1). It does not wrap: it saturates at TIMEOUT while the FSM exits.
// STRUCTURE
//  - Shared package wb_pkg: arb_state_t {ARB_IDLE, ARB_BUSY} and a function onehot_to_idx.
//  - Sub-module wb_rr_pick: combinational round-robin picker.
//      In:  req[NM], last_idx.
//      Out: gnt_onehot[NM], gnt_idx, any.
//    Instantiated once. The top holds the FSM, the grant/last registers, the mux and the watchdog.
// TESTING
//  1 Reset: hold wb_rst_i 3 cycles with all m_cyc_i=1 -> grant_o=0, s_cyc_o=0.
//    First grant after release is 2'b01.
//  2 Contention: both masters keep CYC, each cycle is 1 STB with slave ACK after 2 cycles,
//    10 transfers -> grant alternates 01,10,01,...; 5 each, 1 idle cycle between cycles.
//  3 Locking: master 1 holds CYC for 4 STBs (addr 0x10..0x1C) while master 0 requests
//    -> all 4 go to the slave unchanged, master 0 is granted only after m_cyc_i[1] drops.
//  4 Watchdog: TIMEOUT=8, slave never ACKs a read of 0x0001_0000 from master 0
//    -> m_err_o=2'b01 for 1 cycle, 8 cycles after s_stb_o rose; s_cyc_o=0 that cycle; then IDLE.
//  5 ACK at the timeout edge: TIMEOUT=8, ACK on the 8th wait cycle -> m_ack_o[0]=1, m_err_o=0.
//  6 Reset mid-cycle: assert wb_rst_i while master 1 waits for ACK -> next cycle all outputs 0,
//    a late s_ack_i is not forwarded, master 0 wins the next arbitration.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter types: FSM state encoding and a one-hot to index helper.
package wb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_MASTERS = 8;

  // Only valid for one-hot (or zero) inputs; bits are OR-merged into the index.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx, wrapping modulo NM.
module wb_rr_pick
  import wb_pkg::*;
#(
  parameter int NM = 2,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last_idx,
  output logic [NM-1:0] gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int                     best_d;
  int                     d;
  logic [MAX_MASTERS-1:0] oh8;
  logic [2:0]             idx3;

  always_comb begin
    gnt_onehot = '0;
    best_d     = NM;
    d          = 0;
    // Distance 0 is the master right after last_idx; the nearest requester wins.
    for (int i = 0; i < NM; i++) begin
      d = (i + NM - 1 - int'(last_idx)) % NM;
      if (req[i] && (d < best_d)) begin
        best_d        = d;
        gnt_onehot    = '0;
        gnt_onehot[i] = 1'b1;
      end
    end
    oh8          = '0;
    oh8[NM-1:0]  = gnt_onehot;
    idx3         = onehot_to_idx(oh8);
    gnt_idx      = IW'(idx3);
    any          = |req;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: NM masters share one slave, grant held for the
// whole CYC, and a watchdog ends cycles whose slave never acknowledges.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  output logic [NM-1:0]        grant_o
);

  localparam int IW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW  = DW / 8;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  arb_state_t     state_reg, state_next;
  logic [NM-1:0]  grant_reg, grant_next;
  logic [IW-1:0]  last_reg, last_next;
  logic [WDW-1:0] wd_reg, wd_next;

  logic [NM-1:0]  pick_onehot;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic           busy;
  logic           req_cyc;
  logic           req_stb;
  logic           wd_hit;

  logic [AW-1:0]  adr_term [NM];
  logic [DW-1:0]  dat_term [NM];
  logic [SW-1:0]  sel_term [NM];

  wb_rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .req        (m_cyc_i),
    .last_idx   (last_reg),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // AND-OR mux: with no grant every slave-side field collapses to zero.
  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_mux
      assign adr_term[gi] = grant_reg[gi] ? m_adr_i[gi*AW +: AW] : '0;
      assign dat_term[gi] = grant_reg[gi] ? m_dat_i[gi*DW +: DW] : '0;
      assign sel_term[gi] = grant_reg[gi] ? m_sel_i[gi*SW +: SW] : '0;
    end
  endgenerate

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int i = 0; i < NM; i++) begin
      s_adr_o = s_adr_o | adr_term[i];
      s_dat_o = s_dat_o | dat_term[i];
      s_sel_o = s_sel_o | sel_term[i];
    end
  end

  assign busy    = (state_reg == ARB_BUSY);
  assign req_cyc = busy & (|(grant_reg & m_cyc_i));
  assign req_stb = busy & (|(grant_reg & m_cyc_i & m_stb_i));
  // A coincident ACK beats the timeout.
  assign wd_hit  = (TIMEOUT != 0) && req_stb && !s_ack_i && (wd_reg == WD_MAX);

  assign s_cyc_o = req_cyc & ~wd_hit;
  assign s_stb_o = req_stb & ~wd_hit;
  assign s_we_o  = busy & (|(grant_reg & m_we_i));
  assign m_ack_o = grant_reg & {NM{s_ack_i}};
  assign m_err_o = grant_reg & {NM{wd_hit}};
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_reg;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_BUSY;
          grant_next = pick_onehot;
          last_next  = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (!req_cyc || wd_hit) begin
          state_next = ARB_IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Saturates at the limit; leaving BUSY drops STB and clears it next cycle.
  always_comb begin
    wd_next = wd_reg;
    if ((TIMEOUT == 0) || !req_stb || s_ack_i) begin
      wd_next = '0;
    end else if (wd_reg != WD_MAX) begin
      wd_next = wd_reg + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      last_reg  <= IW'(NM - 1);
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      wd_reg    <= wd_next;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter (NM=2, TIMEOUT=8): directed scenarios plus random traffic,
// every cycle compared against a transaction-level ownership model.
module tb_wb_rr_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr, m_dat;
  logic [7:0]  m_sel;
  logic [31:0] s_dat;
  logic        s_ack;

  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, grant_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NM(2), .AW(32), .DW(32), .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat),
    .s_ack_i  (s_ack),
    .grant_o  (grant_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  // Reference model: who owns the bus (-1 = nobody), who was served last, how long STB waited.
  int mo_owner = -1;
  int mo_last = 1;
  int mo_wait = 0;

  logic [1:0]  obs_grant, obs_ack, obs_err;
  logic        obs_scyc, obs_sstb;
  logic [31:0] obs_adr;

  int acks, nerr, nack, scnt, own, k, t_rise, t_err;
  logic give, stb_now, scyc_err;
  logic [1:0] err_val, ack_val;
  int seq[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_no, got, want);
    end
  endtask

  // One clock: compare at negedge against the model, then advance model and time.
  task automatic step();
    logic [1:0]  e_grant, e_ack, e_err;
    logic        e_cyc, e_stb, e_we, to;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    int          o, c;
    bit          picked;
    @(negedge clk);
    o = mo_owner;
    e_grant = 0; e_ack = 0; e_err = 0; e_cyc = 0; e_stb = 0; e_we = 0;
    e_adr = 0; e_dat = 0; e_sel = 0; to = 0;
    if (o >= 0) begin
      to      = m_cyc[o] && m_stb[o] && !s_ack && (mo_wait == TMO);
      e_grant = 2'(1 << o);
      e_cyc   = m_cyc[o] && !to;
      e_stb   = m_cyc[o] && m_stb[o] && !to;
      e_we    = m_we[o];
      e_adr   = m_adr[o*32 +: 32];
      e_dat   = m_dat[o*32 +: 32];
      e_sel   = m_sel[o*4 +: 4];
      e_ack   = s_ack ? 2'(1 << o) : 2'b00;
      e_err   = to ? 2'(1 << o) : 2'b00;
    end
    check_eq("grant", grant_o, e_grant);
    check_eq("s_cyc", s_cyc_o, e_cyc);
    check_eq("s_stb", s_stb_o, e_stb);
    check_eq("s_we", s_we_o, e_we);
    check_eq("s_adr", s_adr_o, e_adr);
    check_eq("s_dat", s_dat_o, e_dat);
    check_eq("s_sel", s_sel_o, e_sel);
    check_eq("m_ack", m_ack_o, e_ack);
    check_eq("m_err", m_err_o, e_err);
    check_eq("m_dat", m_dat_o, s_dat);
    obs_grant = grant_o; obs_ack = m_ack_o; obs_err = m_err_o;
    obs_scyc = s_cyc_o; obs_sstb = s_stb_o; obs_adr = s_adr_o;
    if (m_ack_o != 0 || m_err_o != 0)
      $display("xfer %0d: grant=%b adr=%08h we=%0b %s", cyc_no, grant_o, s_adr_o, s_we_o,
               (m_err_o != 0) ? "err" : "ack");
    if (rst) begin
      mo_owner = -1; mo_last = 1; mo_wait = 0;
    end else if (o < 0) begin
      picked = 0;
      for (int j = 1; j <= 2; j++) begin
        c = (mo_last + j) % 2;
        if (!picked && m_cyc[c]) begin
          picked = 1; mo_owner = c; mo_last = c; mo_wait = 0;
        end
      end
    end else if (!m_cyc[o] || to) begin
      mo_owner = -1; mo_wait = 0;
    end else if (m_stb[o] && !s_ack) begin
      mo_wait = (mo_wait < TMO) ? mo_wait + 1 : mo_wait;
    end else begin
      mo_wait = 0;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    rst = 1; m_cyc = 0; m_stb = 0; s_ack = 0;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1; m_cyc = 0; m_stb = 0; m_we = 0; m_adr = 0; m_dat = 0; m_sel = 0;
    s_dat = 32'hA5A5_0001; s_ack = 0;
    @(posedge clk);
    #1;

    // Reset held with both masters requesting, then master 0 wins first.
    m_cyc = 2'b11;
    repeat (3) begin
      step();
      check_eq("rst_grant", obs_grant, 2'b00);
      check_eq("rst_scyc", obs_scyc, 1'b0);
    end
    rst = 0;
    step();
    step();
    check_eq("first_grant", obs_grant, 2'b01);
    m_cyc = 0;
    step(); step();

    // Contention: single-STB cycles, slave ACKs two cycles after STB.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b01;
    m_adr = {32'h0000_2000, 32'h0000_1000}; m_dat = {$urandom, $urandom}; m_sel = 8'hF3;
    acks = 0; scnt = 0; seq.delete();
    for (int n = 0; n < 200 && acks < 10; n++) begin
      own = mo_owner;
      stb_now = (own >= 0) && m_cyc[own] && m_stb[own];
      give = stb_now && (scnt == 2);
      s_ack = give;
      s_dat = $urandom;
      step();
      s_ack = 0;
      m_cyc = 2'b11; m_stb = 2'b11;
      if (give) begin
        m_cyc[own] = 0; m_stb[own] = 0;
        seq.push_back(own); acks++; scnt = 0;
      end else if (stb_now) begin
        scnt++;
      end
    end
    check_eq("ctn_count", acks, 10);
    foreach (seq[i]) check_eq("ctn_order", seq[i], i % 2);
    m_cyc = 0; m_stb = 0;
    step(); step();

    // Locking: master 1 runs 4 STBs in one CYC while master 0 waits.
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
    m_adr = {32'h0000_0010, 32'h0000_0F00};
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    k = 0;
    for (int n = 0; n < 40 && k < 4; n++) begin
      give = (mo_owner == 1) && m_cyc[1];
      s_ack = give;
      step();
      s_ack = 0;
      if (give) begin
        check_eq("lock_adr", obs_adr, 32'h10 + 32'(4 * k));
        check_eq("lock_grant", obs_grant, 2'b10);
        k++;
        if (k == 4) begin
          m_cyc[1] = 0; m_stb[1] = 0;
        end else begin
          m_adr[63:32] = m_adr[63:32] + 32'd4;
        end
      end
    end
    check_eq("lock_done", k, 4);
    step(); step(); step();
    check_eq("lock_next", obs_grant, 2'b01);
    m_cyc = 0; m_stb = 0;
    step(); step();

    // Watchdog: slave never ACKs a read from master 0.
    do_reset();
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; m_adr = {32'h0, 32'h0001_0000};
    t_rise = -1; t_err = -1; nerr = 0; err_val = 0; scyc_err = 1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (obs_sstb && t_rise < 0) t_rise = n;
      if (obs_err != 0) begin
        if (t_err < 0) begin
          t_err = n; err_val = obs_err; scyc_err = obs_scyc;
        end
        nerr++;
        m_cyc = 0; m_stb = 0;
      end
    end
    check_eq("wd_err_val", err_val, 2'b01);
    check_eq("wd_latency", t_err - t_rise, TMO);
    check_eq("wd_scyc_at_err", scyc_err, 1'b0);
    check_eq("wd_err_pulses", nerr, 1);

    // ACK on the timeout cycle wins over ERR.
    do_reset();
    m_cyc = 2'b01; m_stb = 2'b01;
    t_rise = -1; nerr = 0; nack = 0; ack_val = 0;
    for (int n = 0; n < 40; n++) begin
      s_ack = (t_rise >= 0) && (n == t_rise + TMO);
      step();
      s_ack = 0;
      if (obs_sstb && t_rise < 0) t_rise = n;
      if (obs_err != 0) nerr++;
      if (obs_ack != 0) begin
        nack++; ack_val = obs_ack; m_cyc = 0; m_stb = 0;
      end
    end
    check_eq("wdack_ack", ack_val, 2'b01);
    check_eq("wdack_count", nack, 1);
    check_eq("wdack_no_err", nerr, 0);

    // Reset while master 1 waits; a late ACK must not reach anyone.
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10;
    step(); step(); step();
    rst = 1;
    step();
    rst = 0; m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1;
    step();
    check_eq("mrst_ack", obs_ack, 2'b00);
    check_eq("mrst_grant", obs_grant, 2'b00);
    check_eq("mrst_scyc", obs_scyc, 1'b0);
    s_ack = 0;
    step();
    check_eq("mrst_next", obs_grant, 2'b01);
    m_cyc = 0; m_stb = 0;
    step();

    // Random traffic, including quiet-slave windows that trip the watchdog.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(7) == 0) m_cyc[i] = ~m_cyc[i];
      m_stb = 2'($urandom_range(3)) | 2'($urandom_range(3));
      m_we  = 2'($urandom);
      m_adr = {$urandom, $urandom};
      m_dat = {$urandom, $urandom};
      m_sel = 8'($urandom);
      s_dat = $urandom;
      s_ack = ((n % 100) >= 30) && ($urandom_range(4) == 0);
      rst   = ($urandom_range(99) == 0);
      step();
    end
    rst = 0; s_ack = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
